aes_job_arbiter: RTL and testbench
==================================

# aes_job_arbiter

Shares one AES core (wrapper with `text_in`/`key`/`mode`/`ld`/`kld`/`done`/`text_out`) between `NREQ` requesters. Each requester submits one job: 128-bit key, 128-bit text, mode bit. The arbiter grants jobs round-robin and sequences the core's key-load, block-load and completion. It returns the result to the owning requester through a valid/ready response. It sits between the bus-side register blocks and the core, replacing direct software pulsing of `ld`/`kld`.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `KLD_WAIT`, 12: cycles to wait after the `kld` pulse before `ld` is issued (1..255).
- `TMO_CYCLES`, 1024: BUSY cycles before a job is aborted (only with `AES_ARB_TIMEOUT_EN`).
- `wb_clk_i`  in  1  clock; everything is on the rising edge.
- `wb_rst_i`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NREQ  job offered by requester i.
- `req_ready`  out  NREQ  one-hot, single-cycle accept of requester i's job.
- `req_mode`  in  NREQ  mode bit per requester.
- `req_key`  in  NREQ*128  key per requester; slice i is [128*i+127:128*i].
- `req_text`  in  NREQ*128  text per requester; same slicing.
- `rsp_valid`  out  NREQ  one-hot result valid for requester i.
- `rsp_ready`  in  NREQ  requester i accepts the result.
- `rsp_text`  out  128  result block.
- `rsp_err`  out  1  result is an abort (timeout); qualified by `rsp_valid`.
- `core_key`  out  128  to core `key`.
- `core_text`  out  128  to core `text_in`.
- `core_mode`  out  1  to core `mode`.
- `core_kld`  out  1  key-load strobe.
- `core_ld`  out  1  block-load strobe.
- `core_done`  in  1  core completion level.
- `core_out`  in  128  core `text_out`.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- States: IDLE, KEYLD, KWAIT, LOAD, BUSY, RESP.
- **IDLE, arbitration**
  - Search `req_valid` starting from `rr_ptr` (reset 0), wrapping at NREQ-1 → 0.
  - On the first hit: pulse `req_ready[i]` for 1 cycle, latch key/text/mode into the `core_*` registers, record `owner`=i.
  - Next state is LOAD if the key cache hits, otherwise KEYLD.
  - Key cache hit: `kvalid`=1 and the latched key equals `last_key`.
- **KEYLD**: `core_kld`=1 for exactly 1 cycle. Set `last_key`=key and `kvalid`=1. Go to KWAIT.
- **KWAIT**: 8-bit counter runs from `KLD_WAIT`-1 down to 0, then go to LOAD.
- **LOAD**: `core_ld`=1 for exactly 1 cycle. Clear the timeout counter. Go to BUSY.
- **BUSY**
  - `core_done` is ignored in the first BUSY cycle, to mask a stale done.
  - From the second cycle on, `core_done`=1 captures `core_out` into `rsp_text`, sets `rsp_err`=0, and goes to RESP.
- **RESP**
  - `rsp_valid[owner]`=1, held stable with `rsp_text`/`rsp_err` until `rsp_ready[owner]`=1.
  - In that handshake cycle: `rr_ptr`=(owner+1) mod NREQ, then go to IDLE.
  - `rsp_ready` of non-owners is ignored.
- **Ordering and boundaries**
  - A requester that drops `req_valid` before grant is simply skipped; no error.
  - All requesters valid: grants rotate strictly, e.g. 0,1,0,1 for NREQ=2.
  - Only one job is in flight. `req_ready` is 0 in every state but IDLE.
- **Core outputs**: `core_key`/`core_text`/`core_mode` stay stable from grant until the next grant.

## Timing
- **Reset values** (async, active-low `wb_rst_i`):
  - state=IDLE, `rr_ptr`=0, `kvalid`=0, `last_key`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_text`=0, `rsp_err`=0.
  - `core_kld`=0, `core_ld`=0, `core_key`=0, `core_text`=0, `core_mode`=0, `busy`=0.
- **Reset mid-job**: abandons the job with no response. The core is not otherwise flushed.
- **Accept cycle**: `req_ready` is registered and asserts the cycle after `req_valid` is seen in IDLE.
- **Key miss**: grant (T) → `core_kld` at T+1 → `core_ld` at T+2+`KLD_WAIT`.
- **Key hit**: grant (T) → `core_ld` at T+1.
- **Response**: `rsp_valid` rises the cycle after `core_done` is sampled in BUSY.
- **Back-to-back**: earliest re-grant is the cycle after the RESP handshake. IDLE is therefore always at least 1 cycle.

## Configuration
- `AES_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter increments every BUSY cycle.
  - When it reaches `TMO_CYCLES` with no done: go to RESP with `rsp_err`=1, `rsp_text`=0, and clear `kvalid`, so the next job reloads its key.
- Undefined: the counter is not built, BUSY waits for done indefinitely, and `rsp_err` is tied to 0.

## Test plan
- **Key miss**: NREQ=2, KLD_WAIT=12. Requester 0 submits key K1, text P; core model returns C 10 cycles after `ld`.
  - `core_kld` exactly 1 cycle, `core_ld` 13 cycles later.
  - `rsp_valid`=01 with `rsp_text`=C and `rsp_err`=0.
- **Key reuse**: second job from requester 1 with key K1 → no `core_kld`; `core_ld` in the cycle after `req_ready[1]`.
- **Round-robin fairness**: both requesters continuously valid for 6 jobs → grant order 0,1,0,1,0,1.
  - `rsp_ready` held low 5 cycles on job 2: `rsp_valid`/`rsp_text` stay stable and no new grant is issued.
- **Stale done**: `core_done` high in the first BUSY cycle and low afterwards → result not captured until the next done.
- **Reset mid-job**: reset asserted during KWAIT → all outputs go to reset values immediately. After release, the same job from requester 0 gets `core_kld` again, because `kvalid`=0.
- **Timeout** (`AES_ARB_TIMEOUT_EN`, TMO_CYCLES=64): core never asserts done → `rsp_err`=1 and `rsp_text`=0 64 cycles after `core_ld`. The next job with the same key issues `core_kld`.

Source files
------------

// File: rtl/aes_job_arbiter.sv
// Round-robin job arbiter in front of a single AES core: grants one requester job at a time,
// sequences kld/ld/done and returns the result. Optional busy timeout: define AES_ARB_TIMEOUT_EN.
module aes_job_arbiter #(
  parameter int NREQ       = 2,
  parameter int KLD_WAIT   = 12,
  parameter int TMO_CYCLES = 1024
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_mode,
  input  logic [NREQ*128-1:0]  req_key,
  input  logic [NREQ*128-1:0]  req_text,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [127:0]         rsp_text,
  output logic                 rsp_err,
  output logic [127:0]         core_key,
  output logic [127:0]         core_text,
  output logic                 core_mode,
  output logic                 core_kld,
  output logic                 core_ld,
  input  logic                 core_done,
  input  logic [127:0]         core_out,
  output logic                 busy
);

  localparam int OW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYLD,
    S_KWAIT,
    S_LOAD,
    S_BUSY,
    S_RESP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [OW-1:0]  rr_ptr;
  logic [OW-1:0]  owner;
  logic [OW-1:0]  gnt_idx;
  logic [OW:0]    scan;
  logic           hit;
  logic           key_hit;
  logic           rsp_hs;
  logic           done_ok;
  logic           tmo_hit;
  logic           first_busy;
  logic           kvalid;
  logic [127:0]   last_key;
  logic [7:0]     kw_cnt;
  logic [127:0]   key_a  [NREQ];
  logic [127:0]   text_a [NREQ];

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign key_a[g]  = req_key[128*g +: 128];
    assign text_a[g] = req_text[128*g +: 128];
  end

  // Round-robin search starting at rr_ptr, wrapping at NREQ-1.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (OW+1)'(k);
      if (scan >= (OW+1)'(NREQ)) scan = scan - (OW+1)'(NREQ);
      if (!hit && req_valid[scan[OW-1:0]]) begin
        hit     = 1'b1;
        gnt_idx = scan[OW-1:0];
      end
    end
  end

  assign key_hit = kvalid && (key_a[gnt_idx] == last_key);
  assign rsp_hs  = (state == S_RESP) && rsp_ready[owner];
  // The first BUSY cycle may still see done from the previous block.
  assign done_ok = (state == S_BUSY) && !first_busy && core_done;
  assign busy    = (state != S_IDLE);

`ifdef AES_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        rsp_err_q;

  assign tmo_hit = (state == S_BUSY) && !done_ok && (tmo_cnt == 16'(TMO_CYCLES - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      tmo_cnt   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == S_LOAD) begin
        tmo_cnt <= '0;
      end else if (state == S_BUSY) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (done_ok) begin
        rsp_err_q <= 1'b0;
      end else if (tmo_hit) begin
        rsp_err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (hit) state_nxt = key_hit ? S_LOAD : S_KEYLD;
      S_KEYLD: state_nxt = S_KWAIT;
      S_KWAIT: if (kw_cnt == 8'd0) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_BUSY;
      S_BUSY:  if (done_ok || tmo_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      rr_ptr     <= '0;
      owner      <= '0;
      kvalid     <= 1'b0;
      last_key   <= '0;
      kw_cnt     <= '0;
      first_busy <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_text   <= '0;
      core_kld   <= 1'b0;
      core_ld    <= 1'b0;
      core_key   <= '0;
      core_text  <= '0;
      core_mode  <= 1'b0;
    end else begin
      req_ready <= '0;
      core_kld  <= 1'b0;
      core_ld   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hit) begin
            req_ready <= onehot(gnt_idx);
            owner     <= gnt_idx;
            core_key  <= key_a[gnt_idx];
            core_text <= text_a[gnt_idx];
            core_mode <= req_mode[gnt_idx];
          end
        end
        S_KEYLD: begin
          core_kld <= 1'b1;
          last_key <= core_key;
          kvalid   <= 1'b1;
          kw_cnt   <= 8'(KLD_WAIT - 1);
        end
        S_KWAIT: begin
          if (kw_cnt != 8'd0) kw_cnt <= kw_cnt - 8'd1;
        end
        S_LOAD: begin
          core_ld    <= 1'b1;
          first_busy <= 1'b1;
        end
        S_BUSY: begin
          first_busy <= 1'b0;
          if (done_ok) begin
            rsp_text  <= core_out;
            rsp_valid <= onehot(owner);
          end else if (tmo_hit) begin
            // Core state is unknown after an abort, so force a key reload next time.
            rsp_text  <= '0;
            rsp_valid <= onehot(owner);
            kvalid    <= 1'b0;
          end
        end
        S_RESP: begin
          if (rsp_hs) begin
            rsp_valid <= '0;
            rr_ptr    <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed/randomized bench for aes_job_arbiter with a behavioural core and arbiter model.
module tb_aes_job_arbiter;
  localparam int NREQ     = 2;
  localparam int KLD_WAIT = 12;
  localparam int TMO      = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_mode = '0;
  logic [NREQ-1:0]     rsp_ready = '0;
  logic [NREQ*128-1:0] req_key = '0;
  logic [NREQ*128-1:0] req_text = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [127:0]        rsp_text;
  logic                rsp_err;
  logic [127:0]        core_key;
  logic [127:0]        core_text;
  logic                core_mode;
  logic                core_kld;
  logic                core_ld;
  logic                core_done;
  logic [127:0]        core_out;
  logic                busy;

  logic                mdl_done = 1'b0;
  logic                stale_lvl = 1'b0;
  logic [127:0]        m_res = '0;
  int                  core_lat = 9;
  bit                  core_hang = 1'b0;
  int                  cd = 0;

  int                  n_chk = 0;
  int                  n_fail = 0;
  int                  cyc = 0;
  int                  m_rr = 0;
  bit                  m_kvalid = 1'b0;
  logic [127:0]        m_lastkey = '0;
  int                  order_q[$];
  logic [127:0]        jk [NREQ];
  logic [127:0]        jt [NREQ];
  logic                jm [NREQ];
  logic [127:0]        K1, K2, K3;

  assign core_done = mdl_done | stale_lvl;
  assign core_out  = m_res;

  aes_job_arbiter #(.NREQ(NREQ), .KLD_WAIT(KLD_WAIT), .TMO_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text), .rsp_err(rsp_err),
    .core_key(core_key), .core_text(core_text), .core_mode(core_mode),
    .core_kld(core_kld), .core_ld(core_ld), .core_done(core_done), .core_out(core_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] t, input logic m);
    return {t[63:0], t[127:64]} ^ k ^ {128{m}};
  endfunction

  // Core model: one-cycle done pulse core_lat+1 cycles after ld, unless hung.
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (core_ld) begin
      cd    <= core_lat;
      m_res <= enc(core_key, core_text, core_mode);
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1 && !core_hang) mdl_done <= 1'b1;
    end
  end

  function automatic logic [NREQ-1:0] oh(input int i);
    oh    = '0;
    oh[i] = 1'b1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_job(input int i, input logic [127:0] k, input logic [127:0] t, input logic m);
    jk[i] = k;
    jt[i] = t;
    jm[i] = m;
    req_key[128*i +: 128]  = k;
    req_text[128*i +: 128] = t;
    req_mode[i]  = m;
    req_valid[i] = 1'b1;
  endtask

  task automatic pool_job(input int i);
    int sel;
    sel = $urandom_range(0, 2);
    set_job(i, (sel == 0) ? K1 : (sel == 1) ? K2 : rnd128(), rnd128(), 1'($urandom_range(0, 1)));
  endtask

  task automatic chk_all_reset(input string tag);
    chk_v({tag, "_req_ready"}, 128'(req_ready), '0);
    chk_v({tag, "_rsp_valid"}, 128'(rsp_valid), '0);
    chk_v({tag, "_rsp_text"}, rsp_text, '0);
    chk_i({tag, "_rsp_err"}, int'(rsp_err), 0);
    chk_v({tag, "_core_key"}, core_key, '0);
    chk_v({tag, "_core_text"}, core_text, '0);
    chk_i({tag, "_core_mode"}, int'(core_mode), 0);
    chk_i({tag, "_core_kld"}, int'(core_kld), 0);
    chk_i({tag, "_core_ld"}, int'(core_ld), 0);
    chk_i({tag, "_busy"}, int'(busy), 0);
  endtask

  // One complete job against the reference model: grant, key load, block load, response.
  task automatic run_job(input int hold, input bit refresh);
    int po, ao, t0, nk, kcyc, lcyc, dcyc, r, exp_r;
    bit got, ehit;
    logic [127:0] ek, et;
    logic em;
    po = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (po < 0 && req_valid[i]) po = i;
    end
    got = 1'b0;
    for (int w = 0; w < 60 && !got; w++) begin
      tick();
      if (req_ready != '0) got = 1'b1;
    end
    chk_i("grant_wait", int'(got), 1);
    if (!got || po < 0) return;
    t0 = cyc;
    ao = 0;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) ao = i;
    order_q.push_back(ao);
    chk_v("req_ready_grant", 128'(req_ready), 128'(oh(po)));
    ek = jk[po];
    et = jt[po];
    em = jm[po];
    chk_v("core_key", core_key, ek);
    chk_v("core_text", core_text, et);
    chk_i("core_mode", int'(core_mode), int'(em));
    ehit = m_kvalid && (ek == m_lastkey);
    if (!ehit) begin
      m_lastkey = ek;
      m_kvalid  = 1'b1;
    end
    if (refresh) pool_job(po);
    else req_valid[po] = 1'b0;

    nk = 0; kcyc = -1; lcyc = -1;
    for (int w = 0; w < KLD_WAIT + 20 && lcyc < 0; w++) begin
      tick();
      if (w == 0) chk_v("ready_pulse", 128'(req_ready), '0);
      if (core_kld) begin nk++; kcyc = cyc; end
      if (core_ld) lcyc = cyc;
    end
    chk_i("kld_count", nk, ehit ? 0 : 1);
    if (!ehit) chk_i("kld_cycle", kcyc, t0 + 1);
    chk_i("ld_cycle", lcyc, ehit ? t0 + 1 : t0 + 2 + KLD_WAIT);
    if (lcyc < 0) return;

    dcyc = -1; r = -1;
    for (int w = 0; w < 400 && r < 0; w++) begin
      tick();
      if (stale_lvl && cyc == lcyc + 1) stale_lvl = 1'b0;
      if (cyc == lcyc + 1) chk_i("ld_pulse", int'(core_ld), 0);
      if (rsp_valid != '0) r = cyc;
      else if (mdl_done && dcyc < 0) dcyc = cyc;
    end
    exp_r = core_hang ? lcyc + TMO : ((dcyc < 0) ? -2 : dcyc + 1);
    chk_i("rsp_cycle", r, exp_r);
    if (r < 0) return;
    chk_v("rsp_valid", 128'(rsp_valid), 128'(oh(po)));
    chk_v("rsp_text", rsp_text, core_hang ? 128'd0 : enc(ek, et, em));
    chk_i("rsp_err", int'(rsp_err), core_hang ? 1 : 0);
    if (core_hang) m_kvalid = 1'b0;

    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~oh(po);
      tick();
      chk_v("hold_rsp_valid", 128'(rsp_valid), 128'(oh(po)));
      chk_v("hold_rsp_text", rsp_text, core_hang ? 128'd0 : enc(ek, et, em));
      chk_v("hold_no_grant", 128'(req_ready), '0);
    end
    rsp_ready = oh(po);
    tick();
    rsp_ready = '0;
    chk_v("rsp_release", 128'(rsp_valid), '0);
    chk_v("idle_no_grant", 128'(req_ready), '0);
    chk_i("idle_busy", int'(busy), 0);
    m_rr = (po + 1) % NREQ;
  endtask

  initial begin
    bit got;
    K1 = rnd128();
    K2 = rnd128();
    K3 = rnd128();

    tick();
    tick();
    chk_all_reset("reset");
    rst_n = 1'b1;

    // Key miss, then key reuse by the other requester.
    core_lat = 9;
    set_job(0, K1, rnd128(), 1'b0);
    run_job(0, 1'b0);
    set_job(1, K1, rnd128(), 1'b1);
    run_job(0, 1'b0);

    // Both requesters continuously valid; third job holds its response.
    pool_job(0);
    pool_job(1);
    for (int j = 0; j < 6; j++) begin
      core_lat = $urandom_range(1, 12);
      run_job((j == 2) ? 5 : 0, 1'b1);
    end
    req_valid = '0;
    for (int j = 0; j < 6; j++) chk_i("rr_order", order_q[j + 2], j % 2);

    // Stale done in the first BUSY cycle.
    core_lat  = 4;
    stale_lvl = 1'b1;
    set_job(0, rnd128(), rnd128(), 1'b1);
    run_job(0, 1'b0);

    // Reset during KWAIT, then the same job again needs a key load.
    set_job(0, K3, rnd128(), 1'b0);
    got = 1'b0;
    for (int w = 0; w < 30 && !got; w++) begin
      tick();
      if (req_ready[0]) got = 1'b1;
    end
    chk_i("rst_grant_wait", int'(got), 1);
    for (int w = 0; w < 5; w++) tick();
    rst_n = 1'b0;
    #1;
    chk_all_reset("midjob_reset");
    tick();
    tick();
    rst_n     = 1'b1;
    m_rr      = 0;
    m_kvalid  = 1'b0;
    m_lastkey = '0;
    core_lat  = 6;
    set_job(0, K3, jt[0], 1'b0);
    run_job(0, 1'b0);

`ifdef AES_ARB_TIMEOUT_EN
    core_hang = 1'b1;
    set_job(0, K3, rnd128(), 1'b1);
    run_job(0, 1'b0);
    core_hang = 1'b0;
    set_job(1, K3, rnd128(), 1'b0);
    run_job(0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
